// File: rtl/hack_loader_pkg.sv
// Shared types and constants for the Hack boot-time ROM loader.
package hack_loader_pkg;

  localparam int HACK_WORD_W    = 16;
  localparam int HACK_BYTE_W    = 8;
  localparam int HACK_MAX_DEPTH = 32768;

  typedef enum logic [2:0] {
    ST_HDR_HI  = 3'd0,
    ST_HDR_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RUN     = 3'd5,
    ST_ERROR   = 3'd6
  } loader_state_e;

endpackage

// File: rtl/hack_rom.sv
// Instruction ROM: one synchronous write port, one combinational read port, no reset.
module hack_rom
  import hack_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [HACK_WORD_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [HACK_WORD_W-1:0] rdata
);

  logic [HACK_WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hack_rom_loader.sv
// Loads a length-prefixed big-endian word stream into the instruction ROM,
// holding the CPU in reset until the final word is written.
module hack_rom_loader
  import hack_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_req,
  input  logic [HACK_BYTE_W-1:0] rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic [15:0]            pcaddr,
  output logic [HACK_WORD_W-1:0] instruction,
  output logic                   cpu_reset,
  output logic                   loading,
  output logic                   load_error,
  output logic [15:0]            words_loaded
);

  localparam logic [16:0] DEPTH_X = 17'(DEPTH);

  loader_state_e          state_q, state_d;
  logic [HACK_BYTE_W-1:0] hi_q, hi_d;
  logic [15:0]            count_q, count_d;
  logic [15:0]            addr_q, addr_d;
  logic [15:0]            words_q, words_d;

  logic                   accept;
  logic                   rom_we;
  logic [15:0]            hdr_cnt;
  logic [15:0]            addr_nxt;
  logic [HACK_WORD_W-1:0] rom_rdata;

  assign loading  = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                    (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO);
  assign rx_ready = reset_n && !load_req && loading;
  assign accept   = rx_valid && rx_ready;
  assign hdr_cnt  = {hi_q, rx_data};
  assign addr_nxt = addr_q + 16'd1;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    count_d = count_q;
    addr_d  = addr_q;
    words_d = words_q;
    rom_we  = 1'b0;
    if (load_req) begin
      state_d = ST_HDR_HI;
      words_d = '0;
    end else begin
      case (state_q)
        ST_HDR_HI: if (accept) begin
          hi_d    = rx_data;
          state_d = ST_HDR_LO;
        end
        ST_HDR_LO: if (accept) begin
          count_d = hdr_cnt;
          // A zero-length or oversized program can never be served correctly.
          if ((hdr_cnt == 16'd0) || ({1'b0, hdr_cnt} > DEPTH_X)) begin
            state_d = ST_ERROR;
          end else begin
            addr_d  = '0;
            state_d = ST_DATA_HI;
          end
        end
        ST_DATA_HI: if (accept) begin
          hi_d    = rx_data;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: if (accept) begin
          rom_we  = 1'b1;
          words_d = addr_nxt;
          if (addr_nxt == count_q) begin
            state_d = ST_RELEASE;
          end else begin
            addr_d  = addr_nxt;
            state_d = ST_DATA_HI;
          end
        end
        ST_RELEASE: state_d = ST_RUN;
        default:    state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_HDR_HI;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
    end
    hi_q    <= hi_d;
    count_q <= count_d;
    addr_q  <= addr_d;
  end

  hack_rom #(.DEPTH(DEPTH), .AW(AW)) u_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (addr_q[AW-1:0]),
    .wdata ({hi_q, rx_data}),
    .raddr (pcaddr[AW-1:0]),
    .rdata (rom_rdata)
  );

  // Outputs decode the state register only; the CPU never sees a half-loaded ROM.
  assign cpu_reset    = (state_q != ST_RUN);
  assign load_error   = (state_q == ST_ERROR);
  assign words_loaded = words_q;
  assign instruction  = ((state_q == ST_RUN) && ({1'b0, pcaddr} < DEPTH_X)) ? rom_rdata : '0;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: vector table for ROM reads plus multi-cycle sequences.
module tb_hack_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_req;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] pcaddr;
  logic [15:0] instruction;
  logic        cpu_reset;
  logic        loading;
  logic        load_error;
  logic [15:0] words_loaded;

  int tests = 0;
  int fails = 0;

  hack_rom_loader #(.DEPTH(1024)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_req     (load_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .pcaddr       (pcaddr),
    .instruction  (instruction),
    .cpu_reset    (cpu_reset),
    .loading      (loading),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t    rd_tab [6];
  logic [7:0] stream [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends every byte of stream; gaps>0 inserts 1..3 idle cycles before each byte.
  task automatic send_stream(input bit gaps);
    foreach (stream[i]) begin
      int budget;
      if (gaps) begin
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      rx_valid = 1'b1;
      rx_data  = stream[i];
      #0;
      budget = 0;
      while (!rx_ready && budget < 50) begin
        tick();
        budget++;
      end
      if (budget >= 50) begin
        chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
        break;
      end
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    #1;
  endtask

  task automatic set_prog3();
    stream = '{8'h00, 8'h03, 8'h30, 8'h39, 8'hEC, 8'h10, 8'h50, 8'h20};
  endtask

  task automatic check_prog3(input string tag);
    foreach (rd_tab[i]) begin
      pcaddr = rd_tab[i].pc;
      #1;
      chk($sformatf("%s_rd_pc%0h", tag, rd_tab[i].pc), 32'(instruction), 32'(rd_tab[i].exp));
    end
  endtask

  initial begin
    rd_tab[0] = '{16'h0000, 16'h3039};
    rd_tab[1] = '{16'h0001, 16'hEC10};
    rd_tab[2] = '{16'h0002, 16'h5020};
    rd_tab[3] = '{16'h7FFF, 16'h0000};
    rd_tab[4] = '{16'h0400, 16'h0000};
    rd_tab[5] = '{16'hFFFF, 16'h0000};

    reset_n  = 1'b0;
    load_req = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    pcaddr   = 16'h0000;
    repeat (2) tick();

    // Reset state
    rx_valid = 1'b1;
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_loading", 32'(loading), 32'd1);
    chk("rst_load_error", 32'(load_error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    rx_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    chk("idle_rx_ready", 32'(rx_ready), 32'd1);

    // N=3 continuous: RELEASE after edge 8, RUN after edge 9
    set_prog3();
    send_stream(1'b0);
    chk("c_words", 32'(words_loaded), 32'd3);
    chk("c_release_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("c_release_loading", 32'(loading), 32'd0);
    chk("c_release_rx_ready", 32'(rx_ready), 32'd0);
    tick();
    chk("c_run_cpu_reset", 32'(cpu_reset), 32'd0);
    check_prog3("c");

    // load_req in RUN with a byte offered on the same cycle
    pcaddr   = 16'h0000;
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    #1;
    chk("lr_rx_ready_blocked", 32'(rx_ready), 32'd0);
    tick();
    load_req = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("lr_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("lr_instr", 32'(instruction), 32'd0);
    chk("lr_words_clr", 32'(words_loaded), 32'd0);
    chk("lr_loading", 32'(loading), 32'd1);
    stream = '{8'h00, 8'h01, 8'h7F, 8'hFF};
    send_stream(1'b0);
    tick();
    chk("lr_reload_words", 32'(words_loaded), 32'd1);
    chk("lr_reload_instr", 32'(instruction), 32'h7FFF);

    // Same N=3 stream with idle gaps restores the same ROM image
    pulse_load_req();
    set_prog3();
    send_stream(1'b1);
    chk("g_release_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    chk("g_run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("g_words", 32'(words_loaded), 32'd3);
    check_prog3("g");

    // Zero-length header
    pulse_load_req();
    stream = '{8'h00, 8'h00};
    send_stream(1'b0);
    chk("z_load_error", 32'(load_error), 32'd1);
    chk("z_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("z_rx_ready", 32'(rx_ready), 32'd0);
    chk("z_loading", 32'(loading), 32'd0);
    tick();
    chk("z_sticky", 32'(load_error), 32'd1);
    pulse_load_req();
    chk("z_clr_load_error", 32'(load_error), 32'd0);
    chk("z_clr_rx_ready", 32'(rx_ready), 32'd1);

    // Oversized header: DEPTH+1 words
    stream = '{8'h04, 8'h01};
    send_stream(1'b0);
    chk("o_load_error", 32'(load_error), 32'd1);
    pulse_load_req();

    // Exactly DEPTH words
    stream = '{8'h04, 8'h00};
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] w;
      w = 16'(i) ^ 16'hA5A5;
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
    end
    send_stream(1'b0);
    chk("f_load_error", 32'(load_error), 32'd0);
    chk("f_words", 32'(words_loaded), 32'd1024);
    tick();
    chk("f_cpu_reset", 32'(cpu_reset), 32'd0);
    pcaddr = 16'd1023;
    #1;
    chk("f_rd_last", 32'(instruction), 32'(16'd1023 ^ 16'hA5A5));
    pcaddr = 16'd0;
    #1;
    chk("f_rd_first", 32'(instruction), 32'h0000A5A5);

    // reset_n mid-load after header plus 3 data bytes
    pulse_load_req();
    stream = '{8'h00, 8'h03, 8'h30, 8'h39, 8'hEC};
    send_stream(1'b0);
    chk("r_words_before", 32'(words_loaded), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("r_words", 32'(words_loaded), 32'd0);
    chk("r_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("r_loading", 32'(loading), 32'd1);
    chk("r_instr", 32'(instruction), 32'd0);
    set_prog3();
    send_stream(1'b0);
    tick();
    chk("r_cpu_reset_run", 32'(cpu_reset), 32'd0);
    chk("r_words_after", 32'(words_loaded), 32'd3);
    check_prog3("r");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Boot-time instruction-memory front end for the Hack CPU. It accepts a program as a byte stream over a valid/ready handshake, writes it into an internal instruction ROM, and holds the CPU in reset while loading. After the last word it releases the CPU and serves `instruction` from `pcaddr` on every cycle. It sits between the host/UART byte source and the CPU's `instruction`/`pcaddr`/`reset` pins.

## Interface
Parameters:
- `DEPTH`, 1024: ROM words; power of two, 2..32768.
- `AW`, $clog2(DEPTH): ROM address width (derived).

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `load_req`  in  1  single-cycle request to (re)start loading; honoured in any state.
- `rx_data`  in  8  program byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `pcaddr`  in  16  CPU program counter.
- `instruction`  out  16  instruction word to CPU.
- `cpu_reset`  out  1  active-high reset to CPU.
- `loading`  out  1  loader is in a byte-accepting state.
- `load_error`  out  1  header rejected; sticky until `load_req` or reset.
- `words_loaded`  out  16  words written in the current load.

## Operation
- Stream format: 2-byte big-endian word count N, then N words, each big-endian (high byte first). Total 2+2N bytes.
- Byte accepted on an edge where `rx_valid && rx_ready`.
- States: HDR_HI, HDR_LO, DATA_HI, DATA_LO, RELEASE, RUN, ERROR.
- HDR_HI accept: latch high byte, go HDR_LO.
- HDR_LO accept: count = {hi, lo}. If count == 0 or count > DEPTH: go ERROR. Otherwise addr = 0, go DATA_HI.
- DATA_HI accept: latch high byte, go DATA_LO.
- DATA_LO accept: write rom[addr] = {hi, lo}; `words_loaded` = addr+1. If addr+1 == count, go RELEASE; else addr++ and go DATA_HI.
- RELEASE: one cycle, then RUN unconditionally.
- RUN and ERROR: hold until `load_req`.
- `load_req` in any state: next state HDR_HI, `words_loaded` cleared, `load_error` cleared.
  - While `load_req` is high, `rx_ready` = 0, so no byte is lost or half-consumed.
- `rx_ready` = reset_n && !load_req && state in {HDR_HI, HDR_LO, DATA_HI, DATA_LO}.
- `loading` = state in {HDR_HI, HDR_LO, DATA_HI, DATA_LO}.
- `cpu_reset` = (state != RUN); decoded from the state register only, with no path from inputs.
- `load_error` = (state == ERROR).
- `instruction` = rom[pcaddr[AW-1:0]] when state == RUN and pcaddr < DEPTH; 16'h0000 otherwise.
  - Read is combinational, zero latency.
  - Words beyond N but below DEPTH return stale ROM contents.
- Reset values: state HDR_HI, `cpu_reset` 1, `rx_ready` 0 (while `reset_n` low), `loading` 1, `load_error` 0, `words_loaded` 0, `instruction` 0. ROM contents are not cleared.

## Timing
- With `rx_valid` held high from edge 1, byte k is accepted on edge k.
- State reaches RELEASE after edge 2N+2 and RUN after edge 2N+3; `cpu_reset` falls after edge 2N+3.
- The CPU therefore always sees at least one reset cycle after the final ROM write.
- `rx_valid` gaps stall the FSM with no timeout; `rx_ready` stays high while waiting.
- `load_req` in RUN: `cpu_reset` rises and `instruction` goes 0 after that edge.
- `reset_n` low mid-load aborts the load. Partially written words stay in ROM but are not served until a complete load reaches RUN.
- Simultaneous `load_req` and `rx_valid`: `load_req` wins and the byte is not accepted.

## Structure
- Package `hack_loader_pkg`:
  - state enum (7 states, 3-bit encoding).
  - `HACK_WORD_W` = 16 and `HACK_BYTE_W` = 8.
  - `HACK_MAX_DEPTH` = 32768.
- Sub-module `hack_rom`: DEPTH×16 array, one synchronous write port, one combinational read port; no reset.
- The loader FSM, counters and output decode live in `hack_rom_loader`.

## Test plan
- Load N=3, bytes 00 03 30 39 EC 10 50 20, `rx_valid` continuous -> `words_loaded` = 3; `cpu_reset` falls after edge 9; `pcaddr` 0/1/2 give 0x3039/0xEC10/0x5020; `pcaddr` 0x7FFF gives 0x0000.
- Same stream with `rx_valid` low for 1–3 random cycles between bytes -> identical ROM contents; `cpu_reset` falls exactly one cycle after the last byte's successor edge.
- Header 00 00 -> ERROR: `load_error` = 1, `cpu_reset` = 1, `rx_ready` = 0. Then `load_req` -> HDR_HI, `load_error` = 0, `rx_ready` = 1.
- Header 04 01 with DEPTH=1024 -> ERROR. Header 04 00 followed by 1024 words -> RUN, and rom[1023] is served at `pcaddr` 1023.
- In RUN, pulse `load_req` with `rx_valid` high on the same cycle -> that byte is not accepted; `cpu_reset` = 1 and `instruction` = 0 next cycle. Reload 00 01 7F FF -> `instruction` = 0x7FFF at `pcaddr` 0.
- `reset_n` low for one cycle after 3 data bytes -> `words_loaded` = 0, `cpu_reset` = 1, state HDR_HI. A full reload then completes normally.
